// File: rtl/ysyx_23060077_axi_sram_slave.sv
// AXI4 responder backed by an internal word-addressed memory.
// It has independent read and write FSMs and supports FIXED and INCR bursts and byte strobes.
// WRAP and reserved bursts get SLVERR, and out-of-range words get DECERR.
// Optional macro YSYX_23060077_AXI_SLV_DELAY_EN adds RD_DELAY wait cycles before
// the first read beat and before the write response.
module ysyx_23060077_axi_sram_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 1024,
    parameter int RD_DELAY   = 4
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    axi_ar_valid_i,
    output logic                    axi_ar_ready_o,
    input  logic [ADDR_WIDTH-1:0]   axi_ar_addr_i,
    input  logic [3:0]              axi_ar_id_i,
    input  logic [7:0]              axi_ar_len_i,
    input  logic [2:0]              axi_ar_size_i,
    input  logic [1:0]              axi_ar_burst_i,
    output logic                    axi_r_valid_o,
    input  logic                    axi_r_ready_i,
    output logic [DATA_WIDTH-1:0]   axi_r_data_o,
    output logic [1:0]              axi_r_resp_o,
    output logic                    axi_r_last_o,
    output logic [3:0]              axi_r_id_o,
    input  logic                    axi_aw_valid_i,
    output logic                    axi_aw_ready_o,
    input  logic [ADDR_WIDTH-1:0]   axi_aw_addr_i,
    input  logic [3:0]              axi_aw_id_i,
    input  logic [7:0]              axi_aw_len_i,
    input  logic [2:0]              axi_aw_size_i,
    input  logic [1:0]              axi_aw_burst_i,
    input  logic                    axi_w_valid_i,
    output logic                    axi_w_ready_o,
    input  logic [DATA_WIDTH-1:0]   axi_w_data_i,
    input  logic [DATA_WIDTH/8-1:0] axi_w_strb_i,
    input  logic                    axi_w_last_i,
    output logic                    axi_b_valid_o,
    input  logic                    axi_b_ready_i,
    output logic [1:0]              axi_b_resp_o,
    output logic [3:0]              axi_b_id_o
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFFB       = $clog2(STRB_WIDTH);
    localparam int IDXW       = $clog2(MEM_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    if (RD_DELAY < 1 || RD_DELAY > 255) begin : g_bad_delay
        $error("RD_DELAY must be in 1..255");
    end
    if ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("MEM_DEPTH must be a power of two");
    end

    typedef enum logic [1:0] {
        R_IDLE,
`ifdef YSYX_23060077_AXI_SLV_DELAY_EN
        R_WAIT,
`endif
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
`ifdef YSYX_23060077_AXI_SLV_DELAY_EN
        W_WAIT,
`endif
        W_DATA,
        W_RESP
    } wr_state_t;

    // Response of one beat: bad burst type first, then address range.
    function automatic logic [1:0] beat_resp(input logic [1:0] burst, input logic [ADDR_WIDTH-1:0] addr);
        if (burst[1])
            return RESP_SLVERR;
        if ((addr >> (OFFB + IDXW)) != '0)
            return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [IDXW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return addr[OFFB +: IDXW];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                         input logic [2:0] size,
                                                         input logic [1:0] burst);
        return (burst == BURST_INCR) ? addr + (ADDR_WIDTH'(1) << size) : addr;
    endfunction

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    rd_state_t             rd_state, rd_state_nx;
    wr_state_t             wr_state, wr_state_nx;
    logic                  active;
    logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
    logic [3:0]            rd_id, wr_id;
    logic [7:0]            rd_len, wr_len, rd_cnt, wr_cnt;
    logic [2:0]            rd_size, wr_size;
    logic [1:0]            rd_burst, wr_burst;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_resp_q, wr_resp;
    logic                  ar_hs, r_hs, aw_hs, w_hs, b_hs, r_last_beat;
    logic                  rd_load;
    logic [ADDR_WIDTH-1:0] rd_load_addr;
    logic [1:0]            rd_load_resp, wr_beat_resp;
`ifdef YSYX_23060077_AXI_SLV_DELAY_EN
    logic [7:0]            rd_dly, wr_dly;
`endif

    assign ar_hs        = axi_ar_valid_i & axi_ar_ready_o;
    assign r_hs         = axi_r_valid_o & axi_r_ready_i;
    assign aw_hs        = axi_aw_valid_i & axi_aw_ready_o;
    assign w_hs         = axi_w_valid_i & axi_w_ready_o;
    assign b_hs         = axi_b_valid_o & axi_b_ready_i;
    assign r_last_beat  = (rd_cnt == rd_len);
    assign wr_beat_resp = beat_resp(wr_burst, wr_addr);

    assign axi_r_data_o = r_data_q;
    assign axi_r_resp_o = r_resp_q;
    assign axi_r_id_o   = rd_id;
    assign axi_b_resp_o = wr_resp;
    assign axi_b_id_o   = wr_id;

    // Pick which address feeds the read data register this cycle.
    always_comb begin
        rd_load      = r_hs & ~r_last_beat;
        rd_load_addr = step_addr(rd_addr, rd_size, rd_burst);
        rd_load_resp = beat_resp(rd_burst, rd_load_addr);
`ifdef YSYX_23060077_AXI_SLV_DELAY_EN
        if (rd_state == R_WAIT && rd_dly == 8'd0) begin
            rd_load      = 1'b1;
            rd_load_addr = rd_addr;
            rd_load_resp = beat_resp(rd_burst, rd_addr);
        end
`else
        if (ar_hs) begin
            rd_load      = 1'b1;
            rd_load_addr = axi_ar_addr_i;
            rd_load_resp = beat_resp(axi_ar_burst_i, axi_ar_addr_i);
        end
`endif
    end

    // Ready outputs stay low until one cycle after reset is released.
    always_ff @(posedge aclk) begin
        active <= areset_n;
    end

    // Read FSM state register.
    always_ff @(posedge aclk) begin
        if (!areset_n)
            rd_state <= R_IDLE;
        else
            rd_state <= rd_state_nx;
    end

    // Read FSM next-state logic.
    always_comb begin
        rd_state_nx = rd_state;
        case (rd_state)
`ifdef YSYX_23060077_AXI_SLV_DELAY_EN
            R_IDLE: if (ar_hs) rd_state_nx = R_WAIT;
            R_WAIT: if (rd_dly == 8'd0) rd_state_nx = R_DATA;
`else
            R_IDLE: if (ar_hs) rd_state_nx = R_DATA;
`endif
            R_DATA: if (r_hs && r_last_beat) rd_state_nx = R_IDLE;
            default: rd_state_nx = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        axi_ar_ready_o = 1'b0;
        axi_r_valid_o  = 1'b0;
        axi_r_last_o   = 1'b0;
        case (rd_state)
            R_IDLE: axi_ar_ready_o = active;
            R_DATA: begin
                axi_r_valid_o = 1'b1;
                axi_r_last_o  = r_last_beat;
            end
            default: ;
        endcase
    end

    // Capture the AR request and walk the burst address and beat count.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            rd_addr  <= '0;
            rd_id    <= '0;
            rd_len   <= '0;
            rd_size  <= '0;
            rd_burst <= '0;
            rd_cnt   <= '0;
        end else if (ar_hs) begin
            rd_addr  <= axi_ar_addr_i;
            rd_id    <= axi_ar_id_i;
            rd_len   <= axi_ar_len_i;
            rd_size  <= axi_ar_size_i;
            rd_burst <= axi_ar_burst_i;
            rd_cnt   <= '0;
        end else if (r_hs && !r_last_beat) begin
            rd_addr  <= rd_load_addr;
            rd_cnt   <= rd_cnt + 8'd1;
        end
    end

    // Read data register; it sees the old memory word if that word is written in the same cycle.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_data_q <= '0;
            r_resp_q <= RESP_OKAY;
        end else if (rd_load) begin
            r_resp_q <= rd_load_resp;
            r_data_q <= (rd_load_resp == RESP_OKAY) ? mem[word_idx(rd_load_addr)] : '0;
        end
    end

    // Write FSM state register.
    always_ff @(posedge aclk) begin
        if (!areset_n)
            wr_state <= W_IDLE;
        else
            wr_state <= wr_state_nx;
    end

    // Write FSM next-state logic.
    always_comb begin
        wr_state_nx = wr_state;
        case (wr_state)
            W_IDLE: if (aw_hs) wr_state_nx = W_DATA;
`ifdef YSYX_23060077_AXI_SLV_DELAY_EN
            W_DATA: if (w_hs && axi_w_last_i) wr_state_nx = W_WAIT;
            W_WAIT: if (wr_dly == 8'd0) wr_state_nx = W_RESP;
`else
            W_DATA: if (w_hs && axi_w_last_i) wr_state_nx = W_RESP;
`endif
            W_RESP: if (b_hs) wr_state_nx = W_IDLE;
            default: wr_state_nx = W_IDLE;
        endcase
    end

    // Write FSM outputs.
    always_comb begin
        axi_aw_ready_o = 1'b0;
        axi_w_ready_o  = 1'b0;
        axi_b_valid_o  = 1'b0;
        case (wr_state)
            W_IDLE:  axi_aw_ready_o = active;
            W_DATA:  axi_w_ready_o  = 1'b1;
            W_RESP:  axi_b_valid_o  = 1'b1;
            default: ;
        endcase
    end

    // Capture the AW request, step the address and keep the worst response of the burst.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            wr_addr  <= '0;
            wr_id    <= '0;
            wr_len   <= '0;
            wr_size  <= '0;
            wr_burst <= '0;
            wr_cnt   <= '0;
            wr_resp  <= RESP_OKAY;
        end else if (aw_hs) begin
            wr_addr  <= axi_aw_addr_i;
            wr_id    <= axi_aw_id_i;
            wr_len   <= axi_aw_len_i;
            wr_size  <= axi_aw_size_i;
            wr_burst <= axi_aw_burst_i;
            wr_cnt   <= '0;
            wr_resp  <= RESP_OKAY;
        end else if (w_hs) begin
            wr_addr  <= step_addr(wr_addr, wr_size, wr_burst);
            wr_cnt   <= wr_cnt + 8'd1;
            wr_resp  <= worst(worst(wr_resp, wr_beat_resp),
                              (axi_w_last_i && wr_cnt != wr_len) ? RESP_SLVERR : RESP_OKAY);
        end
    end

    // Byte-masked memory write; error beats are dropped and contents survive reset.
    always_ff @(posedge aclk) begin
        if (areset_n && w_hs && wr_beat_resp == RESP_OKAY) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (axi_w_strb_i[i])
                    mem[word_idx(wr_addr)][i*8 +: 8] <= axi_w_data_i[i*8 +: 8];
            end
        end
    end

`ifdef YSYX_23060077_AXI_SLV_DELAY_EN
    // Wait counters that hold off the first read beat and the write response.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            rd_dly <= '0;
            wr_dly <= '0;
        end else begin
            if (ar_hs)
                rd_dly <= 8'(RD_DELAY - 1);
            else if (rd_state == R_WAIT && rd_dly != 8'd0)
                rd_dly <= rd_dly - 8'd1;
            if (w_hs && axi_w_last_i)
                wr_dly <= 8'(RD_DELAY - 1);
            else if (wr_state == W_WAIT && wr_dly != 8'd0)
                wr_dly <= wr_dly - 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060077_axi_sram_slave.sv
// Directed self-checking bench for ysyx_23060077_axi_sram_slave.
// Honours YSYX_23060077_AXI_SLV_DELAY_EN (RD_DELAY = 4) when it is defined for the build.
module tb_ysyx_23060077_axi_sram_slave;

`ifdef YSYX_23060077_AXI_SLV_DELAY_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 0;
`endif

    logic        aclk;
    logic        areset_n;
    logic        axi_ar_valid_i, axi_ar_ready_o;
    logic [31:0] axi_ar_addr_i;
    logic [3:0]  axi_ar_id_i;
    logic [7:0]  axi_ar_len_i;
    logic [2:0]  axi_ar_size_i;
    logic [1:0]  axi_ar_burst_i;
    logic        axi_r_valid_o, axi_r_ready_i;
    logic [63:0] axi_r_data_o;
    logic [1:0]  axi_r_resp_o;
    logic        axi_r_last_o;
    logic [3:0]  axi_r_id_o;
    logic        axi_aw_valid_i, axi_aw_ready_o;
    logic [31:0] axi_aw_addr_i;
    logic [3:0]  axi_aw_id_i;
    logic [7:0]  axi_aw_len_i;
    logic [2:0]  axi_aw_size_i;
    logic [1:0]  axi_aw_burst_i;
    logic        axi_w_valid_i, axi_w_ready_o;
    logic [63:0] axi_w_data_i;
    logic [7:0]  axi_w_strb_i;
    logic        axi_w_last_i;
    logic        axi_b_valid_o, axi_b_ready_i;
    logic [1:0]  axi_b_resp_o;
    logic [3:0]  axi_b_id_o;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] wdata [16];
    logic [63:0] rexp  [16];

    ysyx_23060077_axi_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_DEPTH(1024), .RD_DELAY(4)
    ) dut (
        .aclk(aclk), .areset_n(areset_n),
        .axi_ar_valid_i(axi_ar_valid_i), .axi_ar_ready_o(axi_ar_ready_o),
        .axi_ar_addr_i(axi_ar_addr_i), .axi_ar_id_i(axi_ar_id_i),
        .axi_ar_len_i(axi_ar_len_i), .axi_ar_size_i(axi_ar_size_i),
        .axi_ar_burst_i(axi_ar_burst_i),
        .axi_r_valid_o(axi_r_valid_o), .axi_r_ready_i(axi_r_ready_i),
        .axi_r_data_o(axi_r_data_o), .axi_r_resp_o(axi_r_resp_o),
        .axi_r_last_o(axi_r_last_o), .axi_r_id_o(axi_r_id_o),
        .axi_aw_valid_i(axi_aw_valid_i), .axi_aw_ready_o(axi_aw_ready_o),
        .axi_aw_addr_i(axi_aw_addr_i), .axi_aw_id_i(axi_aw_id_i),
        .axi_aw_len_i(axi_aw_len_i), .axi_aw_size_i(axi_aw_size_i),
        .axi_aw_burst_i(axi_aw_burst_i),
        .axi_w_valid_i(axi_w_valid_i), .axi_w_ready_o(axi_w_ready_o),
        .axi_w_data_i(axi_w_data_i), .axi_w_strb_i(axi_w_strb_i),
        .axi_w_last_i(axi_w_last_i),
        .axi_b_valid_o(axi_b_valid_o), .axi_b_ready_i(axi_b_ready_i),
        .axi_b_resp_o(axi_b_resp_o), .axi_b_id_o(axi_b_id_o)
    );

    // Free-running clock.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Hard stop in case a handshake never completes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_arReady"}, axi_ar_ready_o, 0);
        checkOutput({tag, "_awReady"}, axi_aw_ready_o, 0);
        checkOutput({tag, "_wReady"},  axi_w_ready_o,  0);
        checkOutput({tag, "_rValid"},  axi_r_valid_o,  0);
        checkOutput({tag, "_rData"},   axi_r_data_o,   0);
        checkOutput({tag, "_rResp"},   axi_r_resp_o,   0);
        checkOutput({tag, "_rLast"},   axi_r_last_o,   0);
        checkOutput({tag, "_rId"},     axi_r_id_o,     0);
        checkOutput({tag, "_bValid"},  axi_b_valid_o,  0);
        checkOutput({tag, "_bResp"},   axi_b_resp_o,   0);
        checkOutput({tag, "_bId"},     axi_b_id_o,     0);
    endtask

    task automatic writeBurst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                              input logic [3:0] id, input logic [7:0] strb, input int lastAt,
                              input logic [1:0] expResp, input string tag);
        int waitCnt = 0;
        while (!axi_aw_ready_o && waitCnt < 50) begin
            tick();
            waitCnt++;
        end
        checkOutput({tag, "_awReady"}, axi_aw_ready_o, 1);
        axi_aw_valid_i = 1'b1;
        axi_aw_addr_i  = addr;
        axi_aw_len_i   = len;
        axi_aw_size_i  = 3'd3;
        axi_aw_burst_i = burst;
        axi_aw_id_i    = id;
        tick();
        axi_aw_valid_i = 1'b0;
        checkOutput({tag, "_wReady"}, axi_w_ready_o, 1);
        for (int i = 0; i <= lastAt; i++) begin
            axi_w_valid_i = 1'b1;
            axi_w_data_i  = wdata[i];
            axi_w_strb_i  = strb;
            axi_w_last_i  = (i == lastAt);
            tick();
        end
        axi_w_valid_i = 1'b0;
        axi_w_last_i  = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            checkOutput({tag, "_bEarly"}, axi_b_valid_o, 0);
            tick();
        end
        checkOutput({tag, "_bValid"}, axi_b_valid_o, 1);
        checkOutput({tag, "_bResp"},  axi_b_resp_o,  expResp);
        checkOutput({tag, "_bId"},    axi_b_id_o,    id);
        axi_b_ready_i = 1'b1;
        tick();
        axi_b_ready_i = 1'b0;
        checkOutput({tag, "_awBack"}, axi_aw_ready_o, 1);
    endtask

    task automatic readBurst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] id, input logic [1:0] expResp, input int stall,
                             input string tag);
        int waitCnt = 0;
        while (!axi_ar_ready_o && waitCnt < 50) begin
            tick();
            waitCnt++;
        end
        checkOutput({tag, "_arReady"}, axi_ar_ready_o, 1);
        axi_ar_valid_i = 1'b1;
        axi_ar_addr_i  = addr;
        axi_ar_len_i   = len;
        axi_ar_size_i  = 3'd3;
        axi_ar_burst_i = burst;
        axi_ar_id_i    = id;
        tick();
        axi_ar_valid_i = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            checkOutput({tag, "_rEarly"}, axi_r_valid_o, 0);
            tick();
        end
        for (int i = 0; i <= int'(len); i++) begin
            checkOutput($sformatf("%s_rValid%0d", tag, i), axi_r_valid_o, 1);
            checkOutput($sformatf("%s_rData%0d", tag, i),  axi_r_data_o,  rexp[i]);
            checkOutput($sformatf("%s_rResp%0d", tag, i),  axi_r_resp_o,  expResp);
            checkOutput($sformatf("%s_rLast%0d", tag, i),  axi_r_last_o,  (i == int'(len)));
            checkOutput($sformatf("%s_rId%0d", tag, i),    axi_r_id_o,    id);
            if (i == 0 && stall > 0) begin
                axi_r_ready_i = 1'b0;
                repeat (stall) begin
                    tick();
                    checkOutput({tag, "_stallValid"}, axi_r_valid_o, 1);
                    checkOutput({tag, "_stallData"},  axi_r_data_o,  rexp[0]);
                    checkOutput({tag, "_stallLast"},  axi_r_last_o,  (len == 8'd0));
                end
            end
            axi_r_ready_i = 1'b1;
            tick();
        end
        axi_r_ready_i = 1'b0;
        checkOutput({tag, "_arBack"}, axi_ar_ready_o, 1);
    endtask

    // Directed vectors with hand-computed expectations.
    task automatic applyStimulus();
        // Single write then single read.
        wdata[0] = 64'h1122334455667788;
        writeBurst(32'h10, 8'd0, 2'b01, 4'h1, 8'hFF, 0, 2'b00, "single");
        rexp[0] = 64'h1122334455667788;
        readBurst(32'h10, 8'd0, 2'b01, 4'h3, 2'b00, 0, "singleRd");

        // INCR burst of four words.
        for (int i = 0; i < 4; i++) wdata[i] = 64'(i + 1);
        writeBurst(32'h100, 8'd3, 2'b01, 4'h2, 8'hFF, 3, 2'b00, "incr");
        for (int i = 0; i < 4; i++) rexp[i] = 64'(i + 1);
        readBurst(32'h100, 8'd3, 2'b01, 4'h5, 2'b00, 0, "incrRd");

        // Low-half strobe over a zero word, read with backpressure.
        wdata[0] = 64'h0;
        writeBurst(32'h200, 8'd0, 2'b01, 4'h0, 8'hFF, 0, 2'b00, "zero");
        wdata[0] = 64'hFFFFFFFF_AAAAAAAA;
        writeBurst(32'h200, 8'd0, 2'b01, 4'h0, 8'h0F, 0, 2'b00, "strb");
        rexp[0] = 64'h00000000_AAAAAAAA;
        readBurst(32'h200, 8'd0, 2'b01, 4'h7, 2'b00, 3, "strbRd");

        // FIXED burst keeps hitting the same word.
        wdata[0] = 64'hAAAA0000AAAA0000;
        wdata[1] = 64'hBBBB1111BBBB1111;
        writeBurst(32'h400, 8'd1, 2'b00, 4'h4, 8'hFF, 1, 2'b00, "fixed");
        rexp[0] = 64'hBBBB1111BBBB1111;
        rexp[1] = 64'hBBBB1111BBBB1111;
        readBurst(32'h400, 8'd1, 2'b00, 4'h4, 2'b00, 0, "fixedRd");

        // Out-of-range word index MEM_DEPTH gives DECERR.
        rexp[0] = 64'h0;
        readBurst(32'h2000, 8'd0, 2'b01, 4'h9, 2'b11, 0, "decRd");
        wdata[0] = 64'h5555;
        writeBurst(32'h2000, 8'd0, 2'b01, 4'h9, 8'hFF, 0, 2'b11, "decWr");

        // WRAP write is rejected and memory is untouched.
        wdata[0] = 64'hDEADDEADDEADDEAD;
        wdata[1] = 64'hDEADDEADDEADDEAD;
        writeBurst(32'h10, 8'd1, 2'b10, 4'h6, 8'hFF, 1, 2'b10, "wrap");
        rexp[0] = 64'h1122334455667788;
        readBurst(32'h10, 8'd0, 2'b01, 4'h6, 2'b00, 0, "wrapRd");

        // Early w_last on beat 1 of a four-beat burst.
        wdata[0] = 64'h77;
        wdata[1] = 64'h88;
        writeBurst(32'h300, 8'd3, 2'b01, 4'hA, 8'hFF, 1, 2'b10, "early");

        // Overlapping read and write to different words.
        for (int i = 0; i < 4; i++) rexp[i] = 64'(i + 1);
        wdata[0] = 64'hCAFE;
        wdata[1] = 64'hBEEF;
        fork
            readBurst(32'h100, 8'd3, 2'b01, 4'hB, 2'b00, 0, "ovlRd");
            writeBurst(32'h500, 8'd1, 2'b01, 4'hC, 8'hFF, 1, 2'b00, "ovlWr");
        join
        rexp[0] = 64'hCAFE;
        rexp[1] = 64'hBEEF;
        readBurst(32'h500, 8'd1, 2'b01, 4'hC, 2'b00, 0, "ovlChk");
    endtask

    initial begin
        areset_n       = 1'b0;
        axi_ar_valid_i = 1'b0;
        axi_ar_addr_i  = '0;
        axi_ar_id_i    = '0;
        axi_ar_len_i   = '0;
        axi_ar_size_i  = '0;
        axi_ar_burst_i = '0;
        axi_r_ready_i  = 1'b0;
        axi_aw_valid_i = 1'b0;
        axi_aw_addr_i  = '0;
        axi_aw_id_i    = '0;
        axi_aw_len_i   = '0;
        axi_aw_size_i  = '0;
        axi_aw_burst_i = '0;
        axi_w_valid_i  = 1'b0;
        axi_w_data_i   = '0;
        axi_w_strb_i   = '0;
        axi_w_last_i   = 1'b0;
        axi_b_ready_i  = 1'b0;

        tick();
        tick();
        checkAllZero("reset");
        areset_n = 1'b1;
        checkOutput("relArReady0", axi_ar_ready_o, 0);
        tick();
        checkOutput("relArReady1", axi_ar_ready_o, 1);
        checkOutput("relAwReady1", axi_aw_ready_o, 1);

        applyStimulus();

        // Reset in the middle of a read burst.
        axi_ar_valid_i = 1'b1;
        axi_ar_addr_i  = 32'h100;
        axi_ar_len_i   = 8'd3;
        axi_ar_size_i  = 3'd3;
        axi_ar_burst_i = 2'b01;
        axi_ar_id_i    = 4'hD;
        tick();
        axi_ar_valid_i = 1'b0;
        repeat (LAT) tick();
        axi_r_ready_i = 1'b1;
        tick();
        checkOutput("midBeat1", axi_r_data_o, 64'h2);
        areset_n = 1'b0;
        tick();
        axi_r_ready_i = 1'b0;
        checkAllZero("midReset");
        areset_n = 1'b1;
        checkOutput("midRelArReady0", axi_ar_ready_o, 0);
        tick();
        checkOutput("midRelArReady1", axi_ar_ready_o, 1);

        // Memory survives reset.
        rexp[0] = 64'h1122334455667788;
        readBurst(32'h10, 8'd0, 2'b01, 4'hE, 2'b00, 0, "postRst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
